wshb_frame_reader: RTL

WSHB_FRAME_READER -- requirements
Module: wshb_frame_reader

---
 rtl/wshb_frame_reader.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/wshb_frame_reader.sv
// Wishbone burst reader that streams a frame buffer from SDRAM into a downstream pixel FIFO.
// Fetches fixed-length bursts, retries on err/rty, and wraps the word index at the end of each frame.
module wshb_frame_reader #(
  parameter int unsigned FRAME_WORDS = 480000,
  parameter logic [31:0] BASE_ADDR   = 32'h0,
  parameter int unsigned BURST       = 16
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        enable,
  output logic [31:0] adr,
  output logic        cyc,
  output logic        stb,
  output logic        we,
  output logic [3:0]  sel,
  output logic [31:0] dat_ms,
  output logic [2:0]  cti,
  output logic [1:0]  bte,
  input  logic [31:0] dat_sm,
  input  logic        ack,
  input  logic        err,
  input  logic        rty,
  input  logic        walmost_full,
  output logic [31:0] wdata,
  output logic        wvalid,
  output logic        frame_start
);

  localparam int unsigned IW = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
  localparam int unsigned CW = $clog2(BURST);
  localparam logic [CW-1:0] LAST_CNT = CW'(BURST - 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(FRAME_WORDS - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CHECK = 2'd1;
  localparam logic [1:0] S_BURST = 2'd2;
  localparam logic [1:0] S_RETRY = 2'd3;

  logic [1:0]    state, state_n;
  logic [IW-1:0] idx, idx_n, idx_inc;
  logic [CW-1:0] cnt, cnt_n;
  logic          cyc_n, wvalid_n, fs_n;
  logic [31:0]   adr_n, wdata_n;
  logic [2:0]    cti_n;

  assign we     = 1'b0;
  assign sel    = 4'hF;
  assign dat_ms = 32'h0;
  assign bte    = 2'b00;

  function automatic logic [31:0] word_adr(input logic [IW-1:0] i);
    return BASE_ADDR + (32'(i) << 2);
  endfunction

  function automatic logic [2:0] burst_cti(input logic [CW-1:0] c);
    return (c == LAST_CNT) ? 3'b111 : 3'b010;
  endfunction

  // State and all bus/stream outputs are registered from their next values.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state       <= S_IDLE;
      idx         <= '0;
      cnt         <= '0;
      cyc         <= 1'b0;
      stb         <= 1'b0;
      adr         <= BASE_ADDR;
      cti         <= 3'b000;
      wvalid      <= 1'b0;
      wdata       <= 32'h0;
      frame_start <= 1'b0;
    end else begin
      state       <= state_n;
      idx         <= idx_n;
      cnt         <= cnt_n;
      cyc         <= cyc_n;
      stb         <= cyc_n;
      adr         <= adr_n;
      cti         <= cti_n;
      wvalid      <= wvalid_n;
      wdata       <= wdata_n;
      frame_start <= fs_n;
    end
  end

  // Next-state and next-output logic; error/retry outrank ack.
  always_comb begin
    state_n  = state;
    idx_n    = idx;
    cnt_n    = cnt;
    cyc_n    = 1'b0;
    adr_n    = adr;
    cti_n    = 3'b000;
    wvalid_n = 1'b0;
    wdata_n  = wdata;
    fs_n     = 1'b0;
    idx_inc  = (idx == LAST_IDX) ? '0 : idx + IW'(1);
    case (state)
      S_IDLE: begin
        if (enable) state_n = S_CHECK;
      end
      S_CHECK: begin
        if (!walmost_full) begin
          state_n = S_BURST;
          cyc_n   = 1'b1;
          adr_n   = word_adr(idx);
          cti_n   = burst_cti(cnt);
        end
      end
      S_BURST: begin
        if (err || rty) begin
          state_n = S_RETRY;
        end else if (ack) begin
          wvalid_n = 1'b1;
          wdata_n  = dat_sm;
          fs_n     = (idx == '0);
          idx_n    = idx_inc;
          if (cnt == LAST_CNT) begin
            cnt_n   = '0;
            state_n = enable ? S_CHECK : S_IDLE;
          end else begin
            cnt_n = cnt + CW'(1);
            cyc_n = 1'b1;
            adr_n = word_adr(idx_inc);
            cti_n = burst_cti(cnt + CW'(1));
          end
        end else begin
          cyc_n = 1'b1;
          cti_n = cti;
        end
      end
      S_RETRY: begin
        state_n = S_BURST;
        cyc_n   = 1'b1;
        adr_n   = word_adr(idx);
        cti_n   = burst_cti(cnt);
      end
      default: state_n = S_IDLE;
    endcase
  end

endmodule
